// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter that shares one start/fin shift-add
// multiplier between two requesters, with a watchdog that aborts an
// operation the multiplier never finishes.
module mul_arbiter #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
    output logic               ack0,
    output logic               ack1,
    output logic [2*WIDTH-1:0] result,
    output logic               err,
    output logic               busy,
    output logic               owner,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_multiplicand,
    output logic [WIDTH-1:0]   mul_multiplier,
    input  logic               mul_fin,
    input  logic [2*WIDTH-1:0] mul_product
);

    // Watchdog only has to count up to TIMEOUT-1.
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [WDW-1:0] r_wd;
    logic           r_last;   // requester served most recently

    logic w_grant;
    logic w_win;
    logic w_finish;

    // With both requesting, the one not served last wins.
    assign w_grant  = req0 | req1;
    assign w_win    = (req0 & req1) ? ~r_last : req1;
    // fin wins over the watchdog when both land in the same cycle.
    assign w_finish = mul_fin | (r_wd == WD_LAST);

    // Arbitration FSM; every output is a register written here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_wd             <= '0;
            r_last           <= 1'b1;    // favour requester 0 after reset
            ack0             <= 1'b0;
            ack1             <= 1'b0;
            result           <= '0;
            err              <= 1'b0;
            busy             <= 1'b0;
            owner            <= 1'b0;
            mul_start        <= 1'b0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        owner            <= w_win;
                        mul_multiplicand <= w_win ? a1 : a0;
                        mul_multiplier   <= w_win ? b1 : b0;
                        r_wd             <= '0;
                        mul_start        <= 1'b1;
                        busy             <= 1'b1;
                        r_state          <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_wd <= r_wd + WDW'(1);
                    if (w_finish) begin
                        result    <= mul_fin ? mul_product : '0;
                        err       <= ~mul_fin;
                        mul_start <= 1'b0;
                        ack0      <= ~owner;
                        ack1      <= owner;
                        r_last    <= owner;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    // One start-low cycle before the next grant lets the multiplier re-arm.
                    busy    <= 1'b0;
                    err     <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked each cycle against a schedule model.
module tb_mul_arbiter;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst, req0, req1, mul_fin;
    logic [3:0] a0, b0, a1, b1, mul_multiplicand, mul_multiplier;
    logic       ack0, ack1, err, busy, owner, mul_start;
    logic [7:0] result, mul_product;

    always #5 clk = ~clk;

    mul_arbiter #(.WIDTH(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .result(result), .err(err),
        .busy(busy), .owner(owner), .mul_start(mul_start),
        .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
        .mul_fin(mul_fin), .mul_product(mul_product)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Schedule model: an op granted in cycle g with effective length L keeps
    // start high in g+1..g+L, acks in g+L+1, and the next grant can be in g+L+2.
    int         g_cyc    = -1;
    int         m_len    = 0;
    int         m_lat    = 0;   // multiplier latency of the op in flight (0 = never)
    int         next_lat = 3;
    int         mcnt     = 0;
    int         fin_cyc  = -100;
    bit         m_tmo, m_own;
    bit         m_last   = 1'b1;
    logic [3:0] m_a, m_b;
    bit         e_start, e_busy, e_ack0, e_ack1, e_err;
    logic [7:0] e_res;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endfunction

    function automatic bit m_idle(input int x);
        return (g_cyc < 0) || (x >= g_cyc + m_len + 2);
    endfunction

    // Arbitration decision for the current cycle, taken just before the edge.
    task automatic decide();
        bit w;
        if (!rst && m_idle(cyc) && (req0 || req1)) begin
            w      = (req0 && req1) ? !m_last : req1;
            g_cyc  = cyc;
            m_own  = w;
            m_a    = w ? a1 : a0;
            m_b    = w ? b1 : b0;
            m_lat  = next_lat;
            m_tmo  = (m_lat == 0) || (m_lat > TO);
            m_len  = m_tmo ? TO : m_lat;
            m_last = w;
        end
    endtask

    task automatic expect_now();
        bit act, ack;
        act     = (g_cyc >= 0);
        e_start = act && cyc >= g_cyc + 1 && cyc <= g_cyc + m_len;
        e_busy  = act && cyc >= g_cyc + 1 && cyc <= g_cyc + m_len + 1;
        ack     = act && cyc == g_cyc + m_len + 1;
        e_ack0  = ack && !m_own;
        e_ack1  = ack && m_own;
        e_err   = ack && m_tmo;
        e_res   = m_tmo ? 8'd0 : ({4'd0, m_a} * {4'd0, m_b});
        chk("mul_start", 32'(mul_start), 32'(e_start));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("ack0", 32'(ack0), 32'(e_ack0));
        chk("ack1", 32'(ack1), 32'(e_ack1));
        chk("err", 32'(err), 32'(e_err));
        if (e_busy) chk("owner", 32'(owner), 32'(m_own));
        if (e_start) begin
            chk("multiplicand", 32'(mul_multiplicand), 32'(m_a));
            chk("multiplier", 32'(mul_multiplier), 32'(m_b));
        end
        if (ack) chk("result", 32'(result), 32'(e_res));
    endtask

    // Multiplier stand-in: raises fin after m_lat cycles of start.
    task automatic mulm();
        if (mul_start === 1'b1) mcnt++;
        else mcnt = 0;
        mul_fin = (m_lat != 0) && (mcnt == m_lat);
        if (mul_fin) begin
            mul_product = {4'd0, mul_multiplicand} * {4'd0, mul_multiplier};
            fin_cyc = cyc;
        end else begin
            mul_product = 8'($urandom);
        end
    endtask

    task automatic tick();
        decide();
        @(posedge clk);
        #1;
        cyc++;
        expect_now();
        mulm();
    endtask

    task automatic hit_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_start", 32'(mul_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'({ack0, ack1}), 32'd0);
        g_cyc = -1; m_last = 1'b1; m_lat = 0; mcnt = 0; mul_fin = 1'b0;
    endtask

    task automatic wait_ack(input bit which, output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if ((which ? ack1 : ack0) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("ack_seen", 32'(got), 32'd1);
    endtask

    initial begin
        bit got, w, d0, d1;
        int sc, ac, r;
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        mul_fin = 1'b0; mul_product = '0;
        #1 rst = 1'b1;
        #1;
        // reset state
        chk("rst_state", 32'({ack0, ack1, err, busy, owner, mul_start}), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_ops", 32'({mul_multiplicand, mul_multiplier}), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // single request 6*7
        req0 = 1'b1; a0 = 4'b0110; b0 = 4'b0111; next_lat = 3;
        tick();
        chk("single_start", 32'(mul_start), 32'd1);
        chk("single_ops", 32'({mul_multiplicand, mul_multiplier}), 32'h67);
        wait_ack(1'b0, got);
        chk("single_res", 32'(result), 32'd42);
        chk("single_err", 32'(err), 32'd0);
        chk("single_owner", 32'(owner), 32'd0);
        chk("ack_after_fin", 32'(cyc - fin_cyc), 32'd1);
        tick(); req0 = 1'b0;
        tick(); tick();

        // simultaneous requests right after reset
        hit_reset();
        tick(); rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; a0 = 4'd3; b0 = 4'd5; a1 = 4'd15; b1 = 4'd15; next_lat = 2;
        wait_ack(1'b0, got);
        chk("sim_res0", 32'(result), 32'd15);
        chk("sim_gap_done", 32'(mul_start), 32'd0);
        tick(); req0 = 1'b0;
        chk("sim_gap_idle", 32'(mul_start), 32'd0);
        wait_ack(1'b1, got);
        chk("sim_res1", 32'(result), 32'd225);
        tick(); req1 = 1'b0;
        tick();

        // fairness: both held, each re-raises after its ack
        req0 = 1'b1; req1 = 1'b1; next_lat = 2;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int i = 0; i < 60; i++) begin
                tick();
                if (ack0 === 1'b1 || ack1 === 1'b1) begin got = 1'b1; break; end
            end
            chk("fair_seen", 32'(got), 32'd1);
            w = (ack1 === 1'b1);
            chk("fair_order", 32'(w), 32'(k % 2));
            tick();
            if (w) req1 = 1'b0; else req0 = 1'b0;
            tick();
            if (w) req1 = 1'b1; else req0 = 1'b1;
        end
        req1 = 1'b0;
        wait_ack(1'b0, got);
        tick(); req0 = 1'b0;
        tick();

        // timeout: multiplier never finishes
        next_lat = 0; req1 = 1'b1; a1 = 4'd5; b1 = 4'd5;
        sc = 0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mul_start === 1'b1) sc++;
            if (ack1 === 1'b1) begin got = 1'b1; break; end
        end
        chk("tmo_ack", 32'(got), 32'd1);
        chk("tmo_start_cycles", 32'(sc), 32'd15);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_res", 32'(result), 32'd0);
        tick(); req1 = 1'b0;
        chk("tmo_idle", 32'(busy), 32'd0);
        tick();

        // reset two cycles into BUSY
        next_lat = 8; req0 = 1'b1; a0 = 4'd7; b0 = 4'd2;
        tick(); tick();
        hit_reset();
        tick(); req0 = 1'b0;
        tick(); rst = 1'b0;
        ac = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack0 === 1'b1 || ack1 === 1'b1) ac++;
        end
        chk("rst_no_ack", 32'(ac), 32'd0);

        // stray fin while idle, then operand change during BUSY
        mul_fin = 1'b1; mul_product = 8'hAA;
        tick();
        chk("stray_ack", 32'({ack0, ack1, busy}), 32'd0);
        req0 = 1'b1; a0 = 4'd9; b0 = 4'd3; next_lat = 4;
        tick();
        chk("chg_start", 32'(mul_start), 32'd1);
        a0 = 4'd2;
        tick();
        chk("chg_hold", 32'(mul_multiplicand), 32'd9);
        wait_ack(1'b0, got);
        chk("chg_res", 32'(result), 32'd27);
        tick(); req0 = 1'b0;
        tick();

        // randomized traffic
        d0 = 1'b0; d1 = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            tick();
            if (d0) begin req0 = 1'b0; d0 = 1'b0; end
            else if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1; a0 = 4'($urandom); b0 = 4'($urandom);
            end
            if (d1) begin req1 = 1'b0; d1 = 1'b0; end
            else if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1; a1 = 4'($urandom); b1 = 4'($urandom);
            end
            if (e_ack0) d0 = 1'b1;
            if (e_ack1) d1 = 1'b1;
            if ($urandom_range(0, 15) == 0) a0 = 4'($urandom);
            if ($urandom_range(0, 15) == 0) b1 = 4'($urandom);
            r = $urandom_range(0, 9);
            next_lat = (r == 0) ? 0 : (r == 1) ? 15 : (r == 2) ? 16 : $urandom_range(1, 5);
            if (!e_start && $urandom_range(0, 15) == 0) mul_fin = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
